// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and the bit-timing helper
// used by both uart_tx and uart_rx.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side bundle: serial pin in, byte stream out with valid/ready,
// plus error pulses and a busy indication.
interface uart_rx_if;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   modport slave  (input rx, ready, output data, valid, frame_err, overrun, busy);
   modport master (output rx, ready, input data, valid, frame_err, overrun, busy);
endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial pin; resets to the
// idle-high line level so reset never looks like a start bit.
module uart_sync (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);
   logic [1:0] ff_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ff_q <= 2'b11;
      else     ff_q <= {ff_q[0], d_i};
   end

   assign q_o = ff_q[1];
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling off the synchronized pin, one-entry
// valid/ready holding register, framing and overrun pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int BAUD   = 115200,
   parameter int CLK_HZ = 25000000
) (
   input  logic     clk,
   input  logic     rst,
   uart_rx_if.slave bus
);
   localparam int CPB  = clks_per_bit(CLK_HZ, BAUD);
   localparam int HALF = CPB / 2;
   localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;
   localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
   localparam logic [CW-1:0] LAST    = CW'(CPB - 1);

   uart_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          ovr_q, ovr_d;
   logic          rx_s;
   logic          stop_smp;

   uart_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (bus.rx),
      .q_o (rx_s)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = ST_START;
         end
         ST_START: begin
            // A start bit that is high again at its midpoint was a glitch.
            if (cnt_q == HALF_M1) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               state_d   = rx_s ? ST_IDLE : ST_DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DATA: begin
            if (cnt_q == LAST) begin
               cnt_d     = '0;
               shift_d   = {rx_s, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 4'd1;
               if (bit_idx_q == 4'd7) state_d = ST_STOP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_STOP: begin
            // Leave at mid-stop so a back-to-back start edge is not missed.
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign stop_smp = (state_q == ST_STOP) && (cnt_q == LAST);

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
      if (valid_q && bus.ready) valid_d = 1'b0;
      if (stop_smp) begin
         if (!rx_s) begin
            ferr_d = 1'b1;
         end else if (!valid_q || bus.ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
      end
   end

   assign bus.data      = data_q;
   assign bus.valid     = valid_q;
   assign bus.frame_err = ferr_q;
   assign bus.overrun   = ovr_q;
   assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default line rate: a bit-level serial driver,
// a byte scoreboard popped on each valid&&ready, and pulse/timing checks.
module tb_uart_rx;
   localparam int CPB  = 25000000 / 115200;
   localparam int HALF = CPB / 2;
   // Pin-to-flag latency: 2 sync cycles, half start bit, 9 bit times, 1 register.
   localparam int FE_LAT = 2 + HALF + 9 * CPB + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   uart_rx_if bus ();

   uart_rx #(.BAUD(115200), .CLK_HZ(25000000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n = 0, bad = 0;
   int cyc = 0;
   int vcyc = 0, fe_cnt = 0, ov_cnt = 0, both_cnt = 0, fe_cyc = -1;
   logic [7:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      logic [7:0] e;
      if (bus.valid) vcyc++;
      if (bus.frame_err) begin fe_cnt++; fe_cyc = cyc; end
      if (bus.overrun) ov_cnt++;
      if (bus.frame_err && bus.overrun) both_cnt++;
      if (!rst && bus.valid && bus.ready) begin
         n++;
         assert (exp_q.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_byte: observed %0h expected none", bus.data);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n++;
            assert (bus.data === e) else begin
               bad++;
               $error("FAIL sb_data: observed %0h expected %0h", bus.data, e);
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Starts on the next edge; each of the 10 bits lasts exactly CPB cycles.
   task automatic send(input logic [7:0] b, input logic stop, output int t0);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      @(posedge clk); #1;
      t0 = cyc;
      for (int i = 0; i < 10; i++) begin
         bus.rx = f[i];
         repeat (CPB) @(posedge clk);
         #1;
      end
      bus.rx = 1'b1;
   endtask

   task automatic idle(input int c);
      repeat (c) @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_data"},  bus.data, 8'h00);
      chk({tag, "_valid"}, bus.valid, 1'b0);
      chk({tag, "_ferr"},  bus.frame_err, 1'b0);
      chk({tag, "_ovr"},   bus.overrun, 1'b0);
      chk({tag, "_busy"},  bus.busy, 1'b0);
   endtask

   initial begin
      int t0, t1, v0, f0, o0;
      bus.rx = 1'b1;
      bus.ready = 1'b0;

      idle(3);
      chk_reset_outs("reset");
      rst = 1'b0;
      idle(5);

      // Two clean frames, consumer always ready.
      bus.ready = 1'b1;
      v0 = vcyc; f0 = fe_cnt; o0 = ov_cnt;
      exp_q.push_back(8'h55); send(8'h55, 1'b1, t0);
      exp_q.push_back(8'hA3); send(8'hA3, 1'b1, t0);
      idle(20);
      chk("t1_valid_cycles", vcyc - v0, 2);
      chk("t1_ferr", fe_cnt - f0, 0);
      chk("t1_ovr", ov_cnt - o0, 0);
      chk("t1_drained", exp_q.size(), 0);

      // Stop bit low: single framing pulse, no byte, then a good frame.
      v0 = vcyc; f0 = fe_cnt; o0 = ov_cnt;
      send(8'h3C, 1'b0, t0);
      idle(300);
      chk("t2_ferr_count", fe_cnt - f0, 1);
      chk("t2_ferr_cycle", fe_cyc, t0 + FE_LAT);
      chk("t2_no_valid", vcyc - v0, 0);
      chk("t2_busy", bus.busy, 1'b0);
      exp_q.push_back(8'h81); send(8'h81, 1'b1, t0);
      idle(20);
      chk("t2_good_valid", vcyc - v0, 1);
      chk("t2_drained", exp_q.size(), 0);

      // Short low glitch rejected at the start-bit midpoint.
      v0 = vcyc; f0 = fe_cnt; o0 = ov_cnt;
      @(posedge clk); #1;
      bus.rx = 1'b0;
      idle(10);
      chk("t3_busy_in_start", bus.busy, 1'b1);
      idle(40);
      bus.rx = 1'b1;
      idle(200);
      chk("t3_busy_idle", bus.busy, 1'b0);
      chk("t3_no_valid", vcyc - v0, 0);
      chk("t3_ferr", fe_cnt - f0, 0);
      chk("t3_ovr", ov_cnt - o0, 0);

      // Overrun: second byte arrives with the first still held.
      bus.ready = 1'b0;
      v0 = vcyc; f0 = fe_cnt; o0 = ov_cnt;
      exp_q.push_back(8'h11); send(8'h11, 1'b1, t0);
      send(8'h22, 1'b1, t0);
      idle(20);
      chk("t4_valid_held", bus.valid, 1'b1);
      chk("t4_data_kept", bus.data, 8'h11);
      chk("t4_ovr_count", ov_cnt - o0, 1);
      chk("t4_ferr", fe_cnt - f0, 0);
      bus.ready = 1'b1;
      idle(1);
      bus.ready = 1'b0;
      idle(2);
      chk("t4_valid_dropped", bus.valid, 1'b0);
      chk("t4_drained", exp_q.size(), 0);

      // Accept in the exact completion cycle: reload without overrun.
      o0 = ov_cnt; f0 = fe_cnt;
      exp_q.push_back(8'h11); send(8'h11, 1'b1, t0);
      exp_q.push_back(8'h22);
      fork
         send(8'h22, 1'b1, t0);
         begin
            @(posedge clk); #1;
            t1 = cyc;
            idle(FE_LAT - 1);
            chk("t5_ready_cycle", cyc, t1 + FE_LAT - 1);
            bus.ready = 1'b1;
            idle(1);
            bus.ready = 1'b0;
            chk("t5_valid_stays", bus.valid, 1'b1);
            chk("t5_data_new", bus.data, 8'h22);
         end
      join
      idle(5);
      chk("t5_no_ovr", ov_cnt - o0, 0);
      chk("t5_one_left", exp_q.size(), 1);
      bus.ready = 1'b1;
      idle(1);
      bus.ready = 1'b0;
      idle(2);
      chk("t5_drained", exp_q.size(), 0);

      // Reset in the middle of the data bits of 0xF0.
      bus.ready = 1'b1;
      v0 = vcyc; f0 = fe_cnt; o0 = ov_cnt;
      @(posedge clk); #1;
      bus.rx = 1'b0;
      idle(2 + HALF + 3 * CPB);
      chk("t6_busy_mid", bus.busy, 1'b1);
      rst = 1'b1;
      #1;
      chk_reset_outs("t6_rst");
      bus.rx = 1'b1;
      idle(5);
      chk_reset_outs("t6_rst_hold");
      rst = 1'b0;
      idle(3 * CPB);
      chk("t6_idle_after", bus.busy, 1'b0);
      exp_q.push_back(8'h0F); send(8'h0F, 1'b1, t0);
      idle(20);
      chk("t6_valid_cycles", vcyc - v0, 1);
      chk("t6_ferr", fe_cnt - f0, 0);
      chk("t6_ovr", ov_cnt - o0, 0);
      chk("t6_drained", exp_q.size(), 0);

      chk("never_both_flags", both_cnt, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n, bad);
      $finish;
   end
endmodule
